// File: rtl/reg_file_param.sv
// Parametrised CPU register file: byte-enabled write port, NUM_RD combinational
// read ports, optional hardwired zero register, write bypass and sequenced clear.
module reg_file_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   r_addr,
  output logic [NUM_RD*DATA_W-1:0]   r_data,
  input  logic                       w_en,
  input  logic [ADDR_W-1:0]          w_addr,
  input  logic [DATA_W-1:0]          w_data,
  input  logic [DATA_W/8-1:0]        w_be,
  output logic                       w_ready,
  input  logic                       clear_req,
  output logic                       busy,
  output logic                       clear_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BE_W  = DATA_W / 8;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_last;
  logic              wr_accept;
  logic              wr_commit;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int j = 0; j < BE_W; j++) begin
      if (be[j]) res[8*j +: 8] = new_v[8*j +: 8];
    end
    return res;
  endfunction

  assign clr_last  = (state == S_CLEAR) && (clr_cnt == LAST_IDX);
  assign wr_accept = w_en && w_ready;
  // Writes to entry 0 are still handshaken when it is hardwired, just dropped.
  assign wr_commit = wr_accept && !((ZERO_R0 != 0) && (w_addr == '0));

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    w_ready   = 1'b0;
    busy      = 1'b0;
    unique case (state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (clear_req) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        busy = 1'b1;
        if (clr_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clear_done <= clr_last;
      // Holding the counter at 0 in IDLE is the same as loading it on clear_req.
      if (state == S_IDLE) clr_cnt <= '0;
      else                 clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // NOTE: the array is reset on purpose (reset must zero every entry), which keeps it in flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == S_CLEAR) begin
      mem[clr_cnt[ADDR_W-1:0]] <= '0;
    end else if (wr_commit) begin
      mem[w_addr] <= merge_bytes(mem[w_addr], w_data, w_be);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] fwd;

    assign ra  = r_addr[k*ADDR_W +: ADDR_W];
    assign raw = mem[ra];
    assign fwd = ((BYPASS != 0) && wr_commit && (ra == w_addr))
                 ? merge_bytes(raw, w_data, w_be) : raw;
    assign r_data[k*DATA_W +: DATA_W] = ((ZERO_R0 != 0) && (ra == '0)) ? '0 : fwd;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: a bypass and a non-bypass instance share stimulus and
// are compared every cycle against an array-level model, plus literal spot checks.
module tb_reg_file_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NR*AW-1:0] r_addr;
  logic [NR*DW-1:0] r_data_bp, r_data_nb;
  logic             w_en;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic [3:0]       w_be;
  logic             clear_req;
  logic             w_ready_bp, busy_bp, done_bp;
  logic             w_ready_nb, busy_nb, done_nb;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(1), .BYPASS(1)) dut_bp (
    .clk(clk), .reset(reset), .r_addr(r_addr), .r_data(r_data_bp),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be), .w_ready(w_ready_bp),
    .clear_req(clear_req), .busy(busy_bp), .clear_done(done_bp)
  );

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .r_addr(r_addr), .r_data(r_data_nb),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be), .w_ready(w_ready_nb),
    .clear_req(clear_req), .busy(busy_nb), .clear_done(done_nb)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the array contents plus "clear in progress, next index".
  logic [31:0] m_mem [DEPTH];
  bit          m_busy  = 1'b0;
  int          m_idx   = 0;
  bit          m_done  = 1'b0;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [31:0] exp_read(input logic [AW-1:0] a, input bit bypass);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_mem[a];
    if (bypass && w_en && !m_busy && a == w_addr) v = byte_merge(v, w_data, w_be);
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      m_busy  = 1'b0;
      m_idx   = 0;
      m_done  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_mem[m_idx] = 32'h0;
        if (m_idx == DEPTH - 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_idx++;
        end
      end else begin
        if (w_en && w_addr != 0) m_mem[w_addr] = byte_merge(m_mem[w_addr], w_data, w_be);
        if (clear_req) begin
          m_busy = 1'b1;
          m_idx  = 0;
        end
      end
    end
  end

  // Per-cycle comparison, 2 ns after the input change on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_valid) begin
        check("w_ready_bp", {31'b0, w_ready_bp}, {31'b0, !m_busy});
        check("w_ready_nb", {31'b0, w_ready_nb}, {31'b0, !m_busy});
        check("busy_bp", {31'b0, busy_bp}, {31'b0, m_busy});
        check("busy_nb", {31'b0, busy_nb}, {31'b0, m_busy});
        check("clear_done_bp", {31'b0, done_bp}, {31'b0, m_done});
        check("clear_done_nb", {31'b0, done_nb}, {31'b0, m_done});
        for (int k = 0; k < NR; k++) begin
          check($sformatf("r_data_bp[%0d]", k), r_data_bp[k*DW +: DW], exp_read(r_addr[k*AW +: AW], 1'b1));
          check($sformatf("r_data_nb[%0d]", k), r_data_nb[k*DW +: DW], exp_read(r_addr[k*AW +: AW], 1'b0));
        end
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    w_en = 1'b1; w_addr = a; w_data = d; w_be = be;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    r_addr = {a, a};
    #3;
    check({name, "_bp0"}, r_data_bp[31:0], exp);
    check({name, "_bp1"}, r_data_bp[63:32], exp);
    check({name, "_nb0"}, r_data_nb[31:0], exp);
    check({name, "_nb1"}, r_data_nb[63:32], exp);
    @(negedge clk);
  endtask

  initial begin
    int bcnt;
    int done_at;
    bit seen;

    reset = 1'b1; clear_req = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0; w_be = '0; r_addr = '0;
    @(negedge clk);
    reset = 1'b0;
    #3;
    check("reset_busy", {31'b0, busy_bp}, 32'h0);
    check("reset_w_ready", {31'b0, w_ready_bp}, 32'h1);
    check("reset_clear_done", {31'b0, done_bp}, 32'h0);
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) rd_check("reset_read", AW'(a), 32'h0);

    // Byte-enable merge
    wr(5'd5, 32'hFFFF_FFFF, 4'b1111);
    wr(5'd5, 32'h1234_5678, 4'b0101);
    rd_check("byte_en", 5'd5, 32'hFF34_FF78);

    // Bypass vs registered read
    wr(5'd7, 32'hAAAA_AAAA, 4'b1111);
    w_en = 1'b1; w_addr = 5'd7; w_data = 32'h0000_BEEF; w_be = 4'b0011;
    r_addr = {5'd7, 5'd0};
    #3;
    check("bypass_same_cycle", r_data_bp[63:32], 32'hAAAA_BEEF);
    check("nobypass_same_cycle", r_data_nb[63:32], 32'hAAAA_AAAA);
    @(negedge clk);
    w_en = 1'b0;
    #3;
    check("nobypass_next_cycle", r_data_nb[63:32], 32'hAAAA_BEEF);
    check("bypass_next_cycle", r_data_bp[63:32], 32'hAAAA_BEEF);
    @(negedge clk);

    // Hardwired zero register
    w_en = 1'b1; w_addr = 5'd0; w_data = 32'hDEAD_BEEF; w_be = 4'b1111; r_addr = '0;
    #3;
    check("zero_w_ready", {31'b0, w_ready_bp}, 32'h1);
    check("zero_read_bp", r_data_bp[31:0], 32'h0);
    check("zero_read_nb", r_data_nb[31:0], 32'h0);
    @(negedge clk);
    w_en = 1'b0;
    #3;
    check("zero_read_next", r_data_bp[31:0], 32'h0);
    @(negedge clk);

    // Clear sequence with a write held across it
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), 32'h1000_0000 + 32'(a) + 32'h1, 4'b1111);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    w_en = 1'b1; w_addr = 5'd3; w_data = 32'h55; w_be = 4'b1111;
    bcnt = 0; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      #3;
      if (busy_bp) begin
        bcnt++;
        check("clear_w_ready_low", {31'b0, w_ready_bp}, 32'h0);
      end
      if (done_bp) begin
        done_at = i;
        check("clear_done_w_ready", {31'b0, w_ready_bp}, 32'h1);
        break;
      end
      @(negedge clk);
    end
    check("clear_busy_cycles", 32'(bcnt), 32'd32);
    check("clear_done_cycle", 32'(done_at), 32'd32);
    @(negedge clk);
    w_en = 1'b0;
    for (int a = 0; a < DEPTH; a++) rd_check("after_clear", AW'(a), (a == 3) ? 32'h55 : 32'h0);

    // Reset in the 10th CLEAR cycle
    for (int a = 1; a < DEPTH; a++) wr(AW'(a), 32'hC0DE_0000 | 32'(a), 4'b1111);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (9) @(negedge clk);
    #3;
    check("midclear_busy_before_reset", {31'b0, busy_bp}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #3;
    check("midclear_busy_after_reset", {31'b0, busy_bp}, 32'h0);
    check("midclear_w_ready_after_reset", {31'b0, w_ready_bp}, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (done_bp || done_nb) seen = 1'b1;
    end
    check("midclear_no_clear_done", {31'b0, seen}, 32'h0);
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) rd_check("midclear_read", AW'(a), 32'h0);

    // Randomised traffic, checked cycle by cycle against the model
    for (int c = 0; c < 2500; c++) begin
      reset     = ($urandom_range(0, 499) == 0);
      clear_req = ($urandom_range(0, 63) == 0);
      w_en      = 1'($urandom_range(0, 1));
      w_addr    = AW'($urandom_range(0, DEPTH - 1));
      w_data    = $urandom;
      w_be      = 4'($urandom_range(0, 15));
      r_addr    = (NR*AW)'($urandom);
      if ($urandom_range(0, 2) == 0) r_addr[AW +: AW] = w_addr;
      if ($urandom_range(0, 3) == 0) r_addr[0 +: AW] = w_addr;
      @(negedge clk);
    end
    reset = 1'b0; clear_req = 1'b0; w_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
